// File: rtl/shared_alu_arbiter.sv
// Shared integer ALU with two-requester round-robin arbitration, ALU-control
// decode and a registered valid/ready response tagged with the requester ID.
// Optional macro ALU_ARB_BACK2BACK_EN: accept a new request in RESP on the
// same edge the response is consumed, skipping IDLE.
module shared_alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_aluop,
    input  logic             req0_fun7,
    input  logic [2:0]       req0_fun3,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_aluop,
    input  logic             req1_fun7,
    input  logic [2:0]       req1_fun3,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t           state_q, state_d;
    logic             ptr_q;
    logic [1:0]       op_aluop_q;
    logic             op_fun7_q;
    logic [2:0]       op_fun3_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_id_q;

    logic             rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_illegal_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic             grant0, grant1, accept_window, accept, accept_id;
    logic [3:0]       alu_ctrl;
    logic             alu_illegal;
    logic [WIDTH-1:0] alu_result;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
    assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
    assign grant1 = req1_valid & (~req0_valid | ptr_q);

`ifdef ALU_ARB_BACK2BACK_EN
    // RESP is always rsp_valid, so rsp_ready alone marks the handshake there.
    assign accept_window = (state_q == StIdle) | ((state_q == StResp) & rsp_ready);
`else
    assign accept_window = (state_q == StIdle);
`endif

    assign req0_ready = accept_window & grant0;
    assign req1_ready = accept_window & grant1;
    // Grants imply valid, so a ready is already an accept.
    assign accept     = req0_ready | req1_ready;
    assign accept_id  = req1_ready;

    // Decode {aluop, fun7, fun3} into the 4-bit ALU control code and compute.
    always_comb begin
        alu_ctrl    = 4'b0000;
        alu_illegal = 1'b0;
        alu_result  = '0;
        case ({op_aluop_q, op_fun7_q, op_fun3_q})
            6'b00_0_000: alu_ctrl = 4'b0010;
            6'b01_0_000: alu_ctrl = 4'b0110;
            6'b10_0_000: alu_ctrl = 4'b0010;
            6'b10_1_000: alu_ctrl = 4'b0110;
            6'b10_0_111: alu_ctrl = 4'b0000;
            6'b10_1_110: alu_ctrl = 4'b0001;
            default:     alu_illegal = 1'b1;
        endcase
        if (!alu_illegal) begin
            case (alu_ctrl)
                4'b0010: alu_result = op_a_q + op_b_q;
                4'b0110: alu_result = op_a_q - op_b_q;
                4'b0000: alu_result = op_a_q & op_b_q;
                4'b0001: alu_result = op_a_q | op_b_q;
                default: alu_result = '0;
            endcase
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = accept ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, arbitration pointer and operand latches captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            op_aluop_q <= '0;
            op_fun7_q  <= 1'b0;
            op_fun3_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q      <= ~accept_id;
                op_id_q    <= accept_id;
                op_aluop_q <= accept_id ? req1_aluop : req0_aluop;
                op_fun7_q  <= accept_id ? req1_fun7  : req0_fun7;
                op_fun3_q  <= accept_id ? req1_fun3  : req0_fun3;
                op_a_q     <= accept_id ? req1_a     : req0_a;
                op_b_q     <= accept_id ? req1_b     : req0_b;
            end
        end
    end

    // Response registers: loaded in EXEC, held under backpressure, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b1;
            rsp_illegal_q <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= op_id_q;
            rsp_result_q  <= alu_result;
            rsp_zero_q    <= (alu_result == '0);
            rsp_illegal_q <= alu_illegal;
        end else if ((state_q == StResp) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: doc/shared_alu_arbiter.md
Name: shared_alu_arbiter

Overview:
- Shares one integer ALU between two requesters: req0 is the main datapath and req1 is the branch/address-generation unit.
- Arbitrates between the requesters with round-robin priority and decodes {aluOp, fun7, fun3} into the team's 4-bit ALU control code.
- Executes the operation and returns a registered result over a valid/ready response channel tagged with the requester ID.
- Sits between the issue logic and the single ALU instance in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 is granted this cycle.
- req0_aluop  in  2  requester 0 aluOp.
- req0_fun7  in  1  requester 0 funct7 bit.
- req0_fun3  in  3  requester 0 funct3.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_aluop, req1_fun7, req1_fun3, req1_a, req1_b: same as req0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_illegal  out  1  the {aluOp, fun7, fun3} encoding was not decodable.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, priority pointer = 0 (req0 favoured).
  - rsp_valid, rsp_id, rsp_result, rsp_illegal all 0; rsp_zero = 1 (tracks the zero result).
  - Latched operands and control cleared.
  - Reset mid-operation discards any in-flight op; no response is emitted.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant rules: if exactly one valid, grant it. If both valid, grant the requester named by the pointer. If none valid, no grant.
  - reqN_ready = (state == IDLE) & grantN. It is combinational from state, pointer and valids; at most one ready is high per cycle.
  - Accept = reqN_valid & reqN_ready at a rising edge. On accept: latch aluop/fun7/fun3/a/b and ID, set the pointer to the other requester, go to EXEC.
- EXEC (one cycle): decode and compute; register result, zero and illegal; set rsp_valid = 1; go to RESP.
- Decode table, key {aluOp, fun7, fun3}:
  - 00_0_000 -> 0010 ADD, a + b.
  - 01_0_000 -> 0110 SUB, a - b.
  - 10_0_000 -> 0010 ADD.
  - 10_1_000 -> 0110 SUB.
  - 10_0_111 -> 0000 AND.
  - 10_1_110 -> 0001 OR.
  - Any other key -> result 0, rsp_illegal = 1; the response is still delivered.
- Arithmetic: modulo 2^WIDTH, wrap-around with no carry or overflow flag. Example: 0xFFFFFFFF + 1 = 0, rsp_zero = 1.
- RESP:
  - rsp_* outputs stay stable while rsp_valid = 1 and rsp_ready = 0 (backpressure of any length).
  - On rsp_valid & rsp_ready: drop rsp_valid next cycle, go to IDLE.
  - No req*_ready is asserted in RESP.
- Latency: accept at edge T -> rsp_valid high after edge T+1. Minimum issue interval is 3 cycles.
- Requester inputs are sampled only at accept. Changes while not granted are ignored. A deasserted valid before grant withdraws the request legally.

Optional Feature:
- Macro: ALU_ARB_BACK2BACK_EN.
- Defined:
  - In RESP, when rsp_valid & rsp_ready and a request is valid in the same cycle, grant per the IDLE rules and accept directly, going to EXEC and skipping IDLE.
  - rsp_valid then stays low for exactly one cycle (EXEC). Minimum issue interval becomes 2 cycles.
- Undefined: behaviour exactly as above, with RESP -> IDLE always.

Test Plan:
- Reset: assert rst mid-EXEC with req0 add pending -> all outputs return to reset values immediately; no rsp_valid after release.
- Single ADD: req0 with aluop=00, fun7=0, fun3=000, a=5, b=7 -> rsp_valid two edges after accept; rsp_result=12, rsp_id=0, rsp_zero=0, rsp_illegal=0.
- Round-robin: req0 and req1 both held valid for 6 ops -> grants alternate 0,1,0,1,0,1 (req0 first after reset). R-type SUB from req1 with a=3, b=3 returns 0, rsp_zero=1.
- Backpressure: AND 0xF0F0 & 0x0FF0 with rsp_ready held low for 5 cycles -> rsp_result=0x00F0, stable throughout; req*_ready stays 0 until the response is accepted.
- Illegal/wrap:
  - aluop=11, fun3=010 -> rsp_illegal=1, rsp_result=0.
  - ADD 0xFFFFFFFF + 1 -> result 0, rsp_zero=1.
  - OR (10_1_110) 0xA000 | 0x000B -> 0xA00B.
- ALU_ARB_BACK2BACK_EN: continuous req1 valid with rsp_ready=1 -> accepts every 2 cycles. Without the macro -> every 3 cycles.
